// File: rtl/truth_table_characterizer.sv
// Sweeps a 3-input block through rows 0..7 and reads back its 8-bit truth-table code.
// Latency: done 8*(SETTLE_CYCLES+SAMPLE_CYCLES)+1 cycles after start; start ignored while busy, abort ends a sweep.
module truth_table_characterizer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] expected,
  output logic [2:0] stim_out,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_code,
  output logic [7:0] unstable,
  output logic       match
);

  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LD = CNT_W'(SAMPLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [2:0]             row_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ref_q;
  logic [7:0]             exp_q;
  logic                   smp;
  logic [2:0]             bit_idx;

  assign smp     = sync_q[SYNC_STAGES-1];
  assign bit_idx = 3'd7 - row_q;

  // dut_out may come from an unclocked block, so it is only ever read through this chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= dut_out;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !abort) state_d = SETTLE;
      SETTLE: begin
        if (abort)              state_d = IDLE;
        else if (cnt_q == '0)   state_d = SAMPLE;
      end
      SAMPLE: begin
        if (abort)              state_d = IDLE;
        else if (cnt_q == '0)   state_d = (row_q == 3'd7) ? DONE : SETTLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      row_q      <= '0;
      ref_q      <= 1'b0;
      exp_q      <= '0;
      stim_out   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      table_code <= '0;
      unstable   <= '0;
      match      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            exp_q      <= expected;
            table_code <= '0;
            unstable   <= '0;
            match      <= 1'b0;
            row_q      <= '0;
            stim_out   <= '0;
            busy       <= 1'b1;
            cnt_q      <= SETTLE_LD;
          end
        end
        SETTLE: begin
          if (abort) begin
            stim_out <= '0;
            busy     <= 1'b0;
            match    <= 1'b0;
          end else if (cnt_q == '0) begin
            cnt_q <= SAMPLE_LD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        SAMPLE: begin
          if (abort) begin
            stim_out <= '0;
            busy     <= 1'b0;
            match    <= 1'b0;
          end else begin
            // first sample of the row is the reference the rest must agree with
            if (cnt_q == SAMPLE_LD)  ref_q <= smp;
            else if (smp != ref_q)   unstable[bit_idx] <= 1'b1;
            if (cnt_q == '0) begin
              table_code[bit_idx] <= smp;
              if (row_q != 3'd7) begin
                row_q    <= row_q + 3'd1;
                stim_out <= row_q + 3'd1;
                cnt_q    <= SETTLE_LD;
              end
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        DONE: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          stim_out <= '0;
          match    <= (table_code == exp_q) && (unstable == 8'h00);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_characterizer.sv
// Directed bench: a behavioural 3-input gate model is swept under several fault and control scenarios.
module tb_truth_table_characterizer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] expected = 8'h00;
  logic [2:0] stim_out;
  logic       dut_out;
  logic       busy;
  logic       done;
  logic [7:0] table_code;
  logic [7:0] unstable;
  logic       match;

  logic [7:0] model_code = 8'h0E;
  logic       stuck1 = 1'b0;
  logic       glitch = 1'b0;
  logic [2:0] ridx;

  int npass = 0;
  int ntotal = 0;
  int dcyc, ndone, serr;

  assign ridx    = 3'd7 - stim_out;
  assign dut_out = stuck1 | (model_code[ridx] ^ glitch);

  always #5 clk = ~clk;

  truth_table_characterizer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .expected   (expected),
    .stim_out   (stim_out),
    .dut_out    (dut_out),
    .busy       (busy),
    .done       (done),
    .table_code (table_code),
    .unstable   (unstable),
    .match      (match)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Starts a sweep at edge 0 and runs 60 cycles; per cycle k (sampled 1ns after edge k)
  // stim_out/busy are compared against the row schedule and done pulses are recorded.
  task automatic sweep(input logic [7:0] exp, input int abort_cyc, input int restart_cyc,
                       input int glitch_cyc, output int done_cyc, output int n_done,
                       output int stim_err);
    int       es;
    logic     eb;
    logic [2:0] es3;
    done_cyc = -1;
    n_done   = 0;
    stim_err = 0;
    expected = exp;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (abort_cyc >= 0 && k > abort_cyc) begin es = 0; eb = 1'b0; end
      else if (k < 48)                     begin es = k / 6; eb = 1'b1; end
      else if (k == 48)                    begin es = 7; eb = 1'b1; end
      else                                 begin es = 0; eb = 1'b0; end
      es3 = es[2:0];
      if (stim_out !== es3 || busy !== eb) stim_err++;
      if (done === 1'b1) begin n_done++; done_cyc = k; end
      if (k == abort_cyc)   abort = 1'b1;
      if (k == restart_cyc) begin start = 1'b1; expected = 8'hAA; end
      if (k == glitch_cyc)  glitch = 1'b1;
      @(posedge clk); #1;
      abort  = 1'b0;
      start  = 1'b0;
      glitch = 1'b0;
    end
  endtask

  initial begin
    #12;
    check("rst_stim", stim_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_table", table_code, 0);
    check("rst_unstable", unstable, 0);
    check("rst_match", match, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // clean 0x0E gate
    sweep(8'h0E, -1, -1, -1, dcyc, ndone, serr);
    check("a_done_cyc", dcyc, 49);
    check("a_ndone", ndone, 1);
    check("a_sched", serr, 0);
    check("a_table", table_code, 8'h0E);
    check("a_unstable", unstable, 8'h00);
    check("a_match", match, 1);
    repeat (3) @(posedge clk);
    #1;
    check("a_hold_table", table_code, 8'h0E);
    check("a_hold_match", match, 1);

    // output stuck high
    stuck1 = 1'b1;
    sweep(8'h0E, -1, -1, -1, dcyc, ndone, serr);
    stuck1 = 1'b0;
    check("b_table", table_code, 8'hFF);
    check("b_unstable", unstable, 8'h00);
    check("b_match", match, 0);

    // dut_out flips for the second sample of row 5
    sweep(8'h0E, -1, -1, 33, dcyc, ndone, serr);
    check("c_unstable", unstable, 8'h04);
    check("c_table", table_code, 8'h0A);
    check("c_match", match, 0);
    check("c_done_cyc", dcyc, 49);

    // restart attempt while busy
    sweep(8'h0E, -1, 10, -1, dcyc, ndone, serr);
    check("d_ndone", ndone, 1);
    check("d_done_cyc", dcyc, 49);
    check("d_sched", serr, 0);
    check("d_match", match, 1);

    // abort in row 3 keeps partial rows 0..2
    model_code = 8'hA5;
    sweep(8'hA5, 20, -1, -1, dcyc, ndone, serr);
    check("e_ndone", ndone, 0);
    check("e_sched", serr, 0);
    check("e_match", match, 0);
    check("e_table", table_code, 8'hA0);
    check("e_unstable", unstable, 8'h00);
    sweep(8'hA5, -1, -1, -1, dcyc, ndone, serr);
    check("f_done_cyc", dcyc, 49);
    check("f_table", table_code, 8'hA5);
    check("f_match", match, 1);
    model_code = 8'h0E;

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("g_busy", busy, 0);
    @(posedge clk); #1;
    check("g_busy2", busy, 0);
    check("g_table_kept", table_code, 8'hA5);

    // asynchronous reset mid-sweep
    expected = 8'h0E; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #3;
    check("h_pre_table", table_code, 8'h08);
    rst_n = 1'b0;
    #1;
    check("h_rst_stim", stim_out, 0);
    check("h_rst_busy", busy, 0);
    check("h_rst_table", table_code, 0);
    check("h_rst_unstable", unstable, 0);
    check("h_rst_match", match, 0);
    check("h_rst_done", done, 0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    sweep(8'h0E, -1, -1, -1, dcyc, ndone, serr);
    check("h_ndone", ndone, 1);
    check("h_done_cyc", dcyc, 49);
    check("h_match", match, 1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
